// File: rtl/vga_pixel_pipeline.sv
// Two-stage VGA colour pipeline: palette/mono/bar/black colour generation
// with blink, plus hsync/vsync delayed to stay aligned with RGB and blank_n.
module vga_pixel_pipeline #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COLOR_W   = 8,
  parameter int IDX_W     = 2,
  parameter int BLINK_IDX = 1,
  parameter int BLINK_FRM = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_en,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [IDX_W-1:0]     pix_idx,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic [1:0]           mode,
  input  logic                 blink_en,
  input  logic                 pal_we,
  input  logic [IDX_W-1:0]     pal_addr,
  input  logic [3*COLOR_W-1:0] pal_data,
  output logic                 blank_n,
  output logic                 hs_o,
  output logic                 vs_o,
  output logic [COLOR_W-1:0]   R,
  output logic [COLOR_W-1:0]   G,
  output logic [COLOR_W-1:0]   B
);

  localparam int PAL_D = 2**IDX_W;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int RGB_W = 3*COLOR_W;

  logic [RGB_W-1:0] pal [PAL_D];
  logic [15:0]      frm_cnt;
  logic             blink_phase;

  logic             act1, hs1, vs1;
  logic [9:0]       x1;
  logic [IDX_W-1:0] idx1;
  logic [1:0]       mode1;
  logic [RGB_W-1:0] pal1;

  logic [IDX_W-1:0] eff;
  logic             active;
  logic [2:0]       bar;
  logic [RGB_W-1:0] col;

  // Palette storage; written on any clk, regardless of pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_D; i++) pal[i] <= (i == 0) ? '0 : '1;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Frame counter and blink phase, advanced at the first pixel of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b1;
    end else if (pix_en && x == 10'd0 && y == 10'd0) begin
      if (frm_cnt == 16'(BLINK_FRM - 1)) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + 16'd1;
      end
    end
  end

  // Blink substitution and visible-area decode ahead of stage 1.
  always_comb begin
    eff    = pix_idx;
    active = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
    if (blink_en && !blink_phase && pix_idx == IDX_W'(BLINK_IDX)) eff = '0;
  end

  // Stage 1: capture pixel context; the palette is read here so a write in the
  // same clk still returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      x1    <= '0;
      idx1  <= '0;
      mode1 <= '0;
      pal1  <= '0;
    end else if (pix_en) begin
      act1  <= active;
      hs1   <= hs_in;
      vs1   <= vs_in;
      x1    <= x;
      idx1  <= pix_idx;
      mode1 <= mode;
      pal1  <= pal[eff];
    end
  end

  // Colour-bar index from threshold comparators and per-mode colour select.
  always_comb begin
    bar = '0;
    col = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x1) >= k * BAR_W) bar = bar + 3'd1;
    end
    case (mode1)
      2'd0:    col = (idx1 != '0) ? '1 : '0;
      2'd1:    col = pal1;
      2'd2:    col = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
      default: col = '0;
    endcase
    if (!act1) col = '0;
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_n <= 1'b0;
      hs_o    <= 1'b1;
      vs_o    <= 1'b1;
      R       <= '0;
      G       <= '0;
      B       <= '0;
    end else if (pix_en) begin
      blank_n <= act1;
      hs_o    <= hs1;
      vs_o    <= vs1;
      {R, G, B} <= col;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Scoreboard bench: the driver predicts each pixel from a behavioural model and
// queues it; a separate monitor pops and compares on every pixel tick.
module tb_vga_pixel_pipeline;
  localparam int H = 640;
  localparam int V = 480;
  localparam int BFRM = 2;

  logic        clk = 0, rst_n = 0, pix_en = 0;
  logic [9:0]  x = 0, y = 0;
  logic [1:0]  pix_idx = 0, mode = 0, pal_addr = 0;
  logic        hs_in = 1, vs_in = 1, blink_en = 0, pal_we = 0;
  logic [23:0] pal_data = 0;
  logic        blank_n, hs_o, vs_o;
  logic [7:0]  R, G, B;

  vga_pixel_pipeline #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(8), .IDX_W(2),
                       .BLINK_IDX(1), .BLINK_FRM(BFRM)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y), .pix_idx(pix_idx),
    .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .blink_en(blink_en),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .blank_n(blank_n), .hs_o(hs_o), .vs_o(vs_o), .R(R), .G(G), .B(B));

  always #5 clk = ~clk;

  int          nchk = 0, nerr = 0;
  logic [26:0] expq[$];
  logic [23:0] mpal[4];
  int          mfrm;
  logic        mphase;
  logic        mon_on = 0;
  logic        last_ok = 0;
  logic [26:0] last_exp;
  logic        cur_blink = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {blank_n, hs, vs, RGB} for a pixel, from the current model state.
  function automatic logic [26:0] model(input logic [9:0] px, input logic [9:0] py,
                                        input logic [1:0] id, input logic h, input logic v,
                                        input logic [1:0] md, input logic be);
    logic        act;
    logic [23:0] c;
    logic [2:0]  bar;
    logic [1:0]  e;
    act = (px < H) && (py < V);
    c = 24'h0;
    if (act) begin
      case (md)
        2'd0: c = (id != 0) ? 24'hFFFFFF : 24'h0;
        2'd1: begin
          e = (be && !mphase && id == 2'd1) ? 2'd0 : id;
          c = mpal[e];
        end
        2'd2: begin
          bar = 3'(px / (H / 8));
          c = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        end
        default: c = 24'h0;
      endcase
    end
    return {act, h, v, c};
  endfunction

  task automatic cycle(input logic pe, input logic [9:0] px, input logic [9:0] py,
                       input logic [1:0] id, input logic h, input logic v,
                       input logic [1:0] md, input logic we, input logic [1:0] wa,
                       input logic [23:0] wd);
    @(negedge clk);
    pix_en = pe; x = px; y = py; pix_idx = id; hs_in = h; vs_in = v; mode = md;
    blink_en = cur_blink; pal_we = we; pal_addr = wa; pal_data = wd;
    if (pe) expq.push_back(model(px, py, id, h, v, md, cur_blink));
    if (we) mpal[wa] = wd;
    if (pe && px == 0 && py == 0) begin
      if (mfrm == BFRM - 1) begin
        mfrm = 0;
        mphase = !mphase;
      end else begin
        mfrm++;
      end
    end
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic [1:0] id,
                     input logic [1:0] md);
    cycle(1'b1, px, py, id, 1'b0, 1'b0, md, 1'b0, 2'd0, 24'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_blank"}, 32'(blank_n), 32'd0);
    chk({tag, "_hs"}, 32'(hs_o), 32'd1);
    chk({tag, "_vs"}, 32'(vs_o), 32'd1);
    chk({tag, "_rgb"}, 32'({R, G, B}), 32'd0);
  endtask

  // Monitor: on each pixel tick the output belongs to the pixel issued one
  // entry earlier; on idle ticks the outputs must hold.
  initial begin
    logic en;
    logic [26:0] e;
    forever begin
      @(posedge clk);
      en = pix_en;
      #1;
      if (mon_on) begin
        if (en) begin
          if (expq.size() >= 2) begin
            e = expq.pop_front();
            chk("pixel", 32'({blank_n, hs_o, vs_o, R, G, B}), 32'(e));
            last_exp = e;
            last_ok = 1;
          end
        end else if (last_ok) begin
          chk("hold", 32'({blank_n, hs_o, vs_o, R, G, B}), 32'(last_exp));
        end
      end
    end
  end

  initial begin
    mpal[0] = 24'h0; mpal[1] = 24'hFFFFFF; mpal[2] = 24'hFFFFFF; mpal[3] = 24'hFFFFFF;
    mfrm = 0;
    mphase = 1'b1;

    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;
    mon_on = 1;

    // mono
    pix(10, 10, 1, 0);
    pix(10, 10, 0, 0);
    pix(10, 10, 3, 0);
    // blanking boundaries with sync pulses, every mode
    for (int m = 0; m < 4; m++) begin
      cycle(1, 640, 0, 3, 0, 1, 2'(m), 0, 0, 0);
      cycle(1, 0, 480, 3, 1, 0, 2'(m), 0, 0, 0);
      cycle(1, 639, 479, 3, 0, 0, 2'(m), 0, 0, 0);
      cycle(1, 10, 10, 3, 1, 1, 2'(m), 0, 0, 0);
    end
    // palette: same-cycle read sees old entry, next cycle sees new
    cycle(1, 10, 10, 2, 0, 0, 1, 1, 2, 24'h123456);
    pix(11, 10, 2, 1);
    pix(12, 10, 0, 1);
    // colour bars over a full line
    for (int i = 0; i < H; i++) pix(10'(i), 0, 0, 2);
    // blink
    cur_blink = 1;
    for (int f = 0; f < 8; f++) begin
      pix(0, 0, 1, 1);
      pix(5, 5, 1, 1);
      pix(6, 5, 2, 1);
    end
    // freeze mid-line
    pix(20, 20, 1, 0);
    for (int i = 0; i < 5; i++)
      cycle(0, 10'($urandom_range(0, 700)), 10'($urandom_range(0, 500)), 2'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [9:0] rx, ry;
      r = $urandom_range(0, 9);
      rx = 10'($urandom_range(0, 700));
      ry = 10'($urandom_range(0, 520));
      if (r == 0) begin rx = 0; ry = 0; end
      else if (r == 1) rx = 10'($urandom_range(639, 640));
      else if (r == 2) ry = 10'($urandom_range(479, 480));
      cur_blink = 1'($urandom);
      cycle(1'($urandom_range(0, 9) != 0), rx, ry, 2'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
            2'($urandom), 24'($urandom));
    end
    // mid-line asynchronous reset with bright output in flight
    cur_blink = 0;
    pix(30, 30, 1, 0);
    pix(31, 30, 1, 0);
    pix(32, 30, 1, 0);
    @(negedge clk);
    mon_on = 0;
    @(posedge clk);
    #3;
    chk("pre_reset_rgb", 32'({R, G, B}), 32'hFFFFFF);
    rst_n = 0;
    #1;
    chk_reset("async_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
